// File: rtl/arc4_pkg.sv
// Shared types for the ARC4 engine: FSM state encoding and a start-up timing helper.
// Latency: n/a (types and a constant function only).
// Backpressure: n/a.
package arc4_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        KSA_RI,
        KSA_RJ,
        KSA_WJ,
        KSA_WI,
        P_RI,
        P_RJ,
        P_WJ,
        P_WI,
        P_RP,
        P_IN,
        P_OUT
    } state_t;

    // One write per S entry for init, then four cycles per entry for the key schedule.
    function automatic int init_ksa_cycles(input int n_w);
        return 5 * (1 << n_w);
    endfunction

endpackage

// File: rtl/arc4_if.sv
// Control, byte-stream and S-memory signals between the ARC4 engine and its surroundings.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the input stream, out_valid/out_ready on the output stream.
interface arc4_if #(
    parameter int KEY_BYTES = 3,
    parameter int N_W       = 8,
    parameter int LEN_W     = 8
);
    logic                   en;
    logic                   rdy;
    logic [8*KEY_BYTES-1:0] key;
    logic [LEN_W-1:0]       msg_len;
    logic [7:0]             in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [7:0]             out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [N_W-1:0]         mem_addr;
    logic [N_W-1:0]         mem_wrdata;
    logic                   mem_wren;
    logic [N_W-1:0]         mem_rddata;

    // Engine side.
    modport master (
        input  en, key, msg_len, in_data, in_valid, out_ready, mem_rddata,
        output rdy, in_ready, out_data, out_valid, mem_addr, mem_wrdata, mem_wren
    );

    // Controller, stream endpoints and S memory side.
    modport slave (
        output en, key, msg_len, in_data, in_valid, out_ready, mem_rddata,
        input  rdy, in_ready, out_data, out_valid, mem_addr, mem_wrdata, mem_wren
    );
endinterface

// File: rtl/arc4_key_sel.sv
// Key byte selector: wrapping key index counter and byte mux over the latched key.
// Latency: key_byte follows kidx combinationally; kidx moves one step per adv.
// Backpressure: none; advances only when the caller pulses adv.
module arc4_key_sel #(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   adv,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             key_byte
);
    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KW-1:0] LAST = KW'(KEY_BYTES - 1);

    logic [KW-1:0] kidx;

    // Key index wraps at the last key byte instead of using a modulo divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kidx <= '0;
        end else if (clr) begin
            kidx <= '0;
        end else if (adv) begin
            kidx <= (kidx == LAST) ? '0 : kidx + KW'(1);
        end
    end

    // Byte 0 is the most significant byte of the key word.
    always_comb begin
        key_byte = '0;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (kidx == KW'(k)) begin
                key_byte = key[8*(KEY_BYTES-1-k) +: 8];
            end
        end
    end

endmodule

// File: rtl/arc4_engine.sv
// ARC4 engine: S init, key schedule and PRGA byte XOR against one external single-port S memory.
// Latency: 5*2^N_W cycles from start to first PRGA step, then at least 7 cycles per byte.
// Backpressure: in_valid low waits in P_IN, out_ready low holds out_valid/out_data; no S access while waiting.
module arc4_engine
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int N_W       = 8,
    parameter int LEN_W     = 8
) (
    input logic   clk,
    input logic   rst,
    arc4_if.master bus
);
    state_t                 state;
    state_t                 nxt;
    logic [N_W-1:0]         i;
    logic [N_W-1:0]         j;
    logic [N_W-1:0]         si;
    logic [N_W-1:0]         sj;
    logic [N_W-1:0]         rd;
    logic [N_W-1:0]         kb_n;
    logic [N_W-1:0]         j_ksa;
    logic [7:0]             rd8;
    logic [7:0]             pad;
    logic [7:0]             pad_cur;
    logic [7:0]             key_byte;
    logic [7:0]             out_q;
    logic                   pad_ok;
    logic [LEN_W-1:0]       count;
    logic [LEN_W-1:0]       len_q;
    logic [8*KEY_BYTES-1:0] key_q;
    logic                   last_i;
    logic                   last_byte;
    logic                   start;

    assign start     = (state == IDLE) && bus.en;
    assign rd        = bus.mem_rddata;
    assign rd8       = 8'(rd);
    assign kb_n      = N_W'(key_byte);
    assign j_ksa     = j + rd + kb_n;
    // The read data is only valid in the first P_IN cycle; later stall cycles use the latched copy.
    assign pad_cur   = pad_ok ? pad : rd8;
    assign last_i    = &i;
    assign last_byte = (count + LEN_W'(1)) == len_q;
    assign bus.out_data = out_q;

    arc4_key_sel #(.KEY_BYTES(KEY_BYTES)) u_key_sel (
        .clk      (clk),
        .rst      (rst),
        .clr      (start),
        .adv      (state == KSA_WI),
        .key      (key_q),
        .key_byte (key_byte)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // Next-state sequencing through init, key schedule and per-byte PRGA.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:   if (bus.en) nxt = INIT;
            INIT:   if (last_i) nxt = KSA_RI;
            KSA_RI: nxt = KSA_RJ;
            KSA_RJ: nxt = KSA_WJ;
            KSA_WJ: nxt = KSA_WI;
            KSA_WI: begin
                if (last_i) nxt = (len_q == '0) ? IDLE : P_RI;
                else        nxt = KSA_RI;
            end
            P_RI:   nxt = P_RJ;
            P_RJ:   nxt = P_WJ;
            P_WJ:   nxt = P_WI;
            P_WI:   nxt = P_RP;
            P_RP:   nxt = P_IN;
            P_IN:   if (bus.in_valid) nxt = P_OUT;
            P_OUT:  if (bus.out_ready) nxt = last_byte ? IDLE : P_RI;
            default: nxt = IDLE;
        endcase
    end

    // Memory port and handshake outputs decoded from the current state.
    always_comb begin
        bus.rdy        = (state == IDLE);
        bus.in_ready   = (state == P_IN) && bus.in_valid;
        bus.out_valid  = (state == P_OUT);
        bus.mem_addr   = '0;
        bus.mem_wrdata = '0;
        bus.mem_wren   = 1'b0;
        case (state)
            INIT:   begin bus.mem_addr = i; bus.mem_wrdata = i; bus.mem_wren = 1'b1; end
            KSA_RI: bus.mem_addr = i;
            KSA_RJ: bus.mem_addr = j_ksa;
            KSA_WJ: begin bus.mem_addr = j; bus.mem_wrdata = si; bus.mem_wren = 1'b1; end
            KSA_WI: begin bus.mem_addr = i; bus.mem_wrdata = sj; bus.mem_wren = 1'b1; end
            P_RI:   bus.mem_addr = i + N_W'(1);
            P_RJ:   bus.mem_addr = j + rd;
            P_WJ:   begin bus.mem_addr = j; bus.mem_wrdata = si; bus.mem_wren = 1'b1; end
            P_WI:   begin bus.mem_addr = i; bus.mem_wrdata = sj; bus.mem_wren = 1'b1; end
            P_RP:   bus.mem_addr = si + sj;
            default: ;
        endcase
    end

    // Index, swap temporaries, pad latch, byte counter and output byte register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i      <= '0;
            j      <= '0;
            si     <= '0;
            sj     <= '0;
            pad    <= '0;
            pad_ok <= 1'b0;
            count  <= '0;
            len_q  <= '0;
            key_q  <= '0;
            out_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        key_q  <= bus.key;
                        len_q  <= bus.msg_len;
                        i      <= '0;
                        j      <= '0;
                        count  <= '0;
                        pad_ok <= 1'b0;
                    end
                end
                INIT: begin
                    i <= i + N_W'(1);
                    j <= '0;
                end
                KSA_RJ: begin
                    si <= rd;
                    j  <= j_ksa;
                end
                KSA_WJ: sj <= rd;
                KSA_WI: begin
                    i <= i + N_W'(1);
                    if (last_i) j <= '0;
                end
                P_RI: i <= i + N_W'(1);
                P_RJ: begin
                    si <= rd;
                    j  <= j + rd;
                end
                P_WJ: sj <= rd;
                P_IN: begin
                    if (!pad_ok) begin
                        pad    <= rd8;
                        pad_ok <= 1'b1;
                    end
                    if (bus.in_valid) out_q <= bus.in_data ^ pad_cur;
                end
                P_OUT: begin
                    if (bus.out_ready) begin
                        count  <= count + LEN_W'(1);
                        pad_ok <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
